// File: rtl/cla_pkg.sv
// cla_pkg: shared definitions for the pipelined carry-lookahead adder.
//   OP_ADD / OP_SUB : encodings of the op input.
//   cla_stages()    : number of pipeline stages (one lookahead group each).
package cla_pkg;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   function automatic int cla_stages(input int width, input int chunk);
      return width / chunk;
   endfunction

endpackage

// File: rtl/cla_group.sv
// cla_group: combinational CHUNK-bit carry-lookahead group.
// Ports:
//   a, b  in  CHUNK  operand chunks (b already inverted for subtract)
//   cin   in  1      carry into bit 0 of the group
//   sum   out CHUNK  group sum
//   cout  out 1      carry out of the group (G | P & cin)
//   p     out 1      group propagate (all bits propagate)
//   g     out 1      group generate (carry out with cin = 0)
module cla_group #(
   parameter int CHUNK = 8
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] sum,
   output logic             cout,
   output logic             p,
   output logic             g
);

   logic [CHUNK-1:0] gen;
   logic [CHUNK-1:0] prop;
   logic [CHUNK-1:0] c;
   logic [CHUNK:0]   gg;

   assign gen  = a & b;
   assign prop = a ^ b;

   // Bit carries are expanded from cin; group G is the same expansion with
   // a zero carry-in, so the group carry-out never waits on the bit chain.
   always_comb begin
      c     = '0;
      gg    = '0;
      c[0]  = cin;
      for (int i = 0; i < CHUNK - 1; i++) begin
         c[i+1] = gen[i] | (prop[i] & c[i]);
      end
      for (int i = 0; i < CHUNK; i++) begin
         gg[i+1] = gen[i] | (prop[i] & gg[i]);
      end
   end

   assign p    = &prop;
   assign g    = gg[CHUNK];
   assign cout = g | (p & cin);
   assign sum  = prop ^ c;

endmodule

// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: pipelined carry-lookahead adder/subtractor, one CHUNK-bit
// lookahead group per stage, inter-group carry registered between stages.
// Optional feature macro: CLA_PIPE_FLAGS_EN (registered ovf / zero flags).
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready input handshake (in_ready = !out_valid | out_ready)
//   a, b, op          operands, op 0 = add, 1 = subtract (a - b)
//   out_valid/out_ready output handshake
//   sum, cout         result and carry out (subtract: 1 = no borrow)
//   ovf, zero         signed overflow / zero result (0 unless flags enabled)
module cla_pipe_adder
   import cla_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   localparam int STAGES = cla_stages(WIDTH, CHUNK);

   logic             advance;
   logic [WIDTH-1:0] b_x;
   logic             cin0;

   // The whole pipe moves together; a stalled output freezes every stage.
   assign advance  = !out_valid || out_ready;
   assign in_ready = advance;

   assign b_x  = (op == OP_SUB) ? ~b : b;
   assign cin0 = (op == OP_SUB);

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int DONE = (k + 1) * CHUNK;
      localparam int REM  = WIDTH - DONE;

      logic [CHUNK-1:0] a_c;
      logic [CHUNK-1:0] b_c;
      logic [CHUNK-1:0] s_c;
      logic             cin_c;
      logic             co_c;
      logic             p_c;
      logic             g_c;
      logic             unused_pg;
      logic             vld_in;
      logic [DONE-1:0]  sum_nx;
      logic             vld_q;
      logic             cy_q;
      logic [DONE-1:0]  sum_q;

      // Stage k takes its operand chunk from the inputs (k = 0) or from the
      // operand bits carried forward by the previous stage.
      if (k == 0) begin : g_src
         assign a_c    = a[CHUNK-1:0];
         assign b_c    = b_x[CHUNK-1:0];
         assign cin_c  = cin0;
         assign vld_in = in_valid;
         assign sum_nx = s_c;
      end else begin : g_src
         assign a_c    = g_stage[k-1].g_ops.a_q[CHUNK-1:0];
         assign b_c    = g_stage[k-1].g_ops.b_q[CHUNK-1:0];
         assign cin_c  = g_stage[k-1].cy_q;
         assign vld_in = g_stage[k-1].vld_q;
         assign sum_nx = {s_c, g_stage[k-1].sum_q};
      end

      cla_group #(
         .CHUNK(CHUNK)
      ) u_group (
         .a   (a_c),
         .b   (b_c),
         .cin (cin_c),
         .sum (s_c),
         .cout(co_c),
         .p   (p_c),
         .g   (g_c)
      );

      // Group P/G are already folded into co_c inside the group.
      assign unused_pg = p_c ^ g_c;

      // ---- stage k register boundary ----
      always_ff @(posedge clk) begin
         if (rst) begin
            vld_q <= 1'b0;
            if (k == STAGES - 1) begin
               sum_q <= '0;
               cy_q  <= 1'b0;
            end
         end else if (advance) begin
            vld_q <= vld_in;
            sum_q <= sum_nx;
            cy_q  <= co_c;
         end
      end

      // Only the not-yet-added upper operand bits travel with the token.
      if (k < STAGES - 1) begin : g_ops
         logic [REM-1:0] a_nx;
         logic [REM-1:0] b_nx;
         logic [REM-1:0] a_q;
         logic [REM-1:0] b_q;

         if (k == 0) begin : g_first
            assign a_nx = a[WIDTH-1:CHUNK];
            assign b_nx = b_x[WIDTH-1:CHUNK];
         end else begin : g_next
            assign a_nx = g_stage[k-1].g_ops.a_q[REM+CHUNK-1:CHUNK];
            assign b_nx = g_stage[k-1].g_ops.b_q[REM+CHUNK-1:CHUNK];
         end

         always_ff @(posedge clk) begin
            if (advance) begin
               a_q <= a_nx;
               b_q <= b_nx;
            end
         end
      end
   end

   assign out_valid = g_stage[STAGES-1].vld_q;
   assign sum       = g_stage[STAGES-1].sum_q;
   assign cout      = g_stage[STAGES-1].cy_q;

`ifdef CLA_PIPE_FLAGS_EN
   logic ovf_nx;
   logic ovf_q;
   logic zero_q;

   // Carry into the MSB is a ^ b ^ sum at that bit; overflow when it
   // differs from the carry out of the MSB.
   assign ovf_nx = g_stage[STAGES-1].a_c[CHUNK-1] ^ g_stage[STAGES-1].b_c[CHUNK-1]
                 ^ g_stage[STAGES-1].s_c[CHUNK-1] ^ g_stage[STAGES-1].co_c;

   // ---- flag register boundary (aligned with last stage) ----
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_q  <= 1'b0;
         zero_q <= 1'b0;
      end else if (advance) begin
         ovf_q  <= ovf_nx;
         zero_q <= ~|g_stage[STAGES-1].sum_nx;
      end
   end

   assign ovf  = ovf_q;
   assign zero = zero_q;
`else
   assign ovf  = 1'b0;
   assign zero = 1'b0;
`endif

endmodule

// File: tb/tb_cla_pipe_adder.sv
// tb_cla_pipe_adder: directed self-checking bench for cla_pipe_adder at
// default parameters (WIDTH 32, CHUNK 8, 4 stages). Flag expectations follow
// CLA_PIPE_FLAGS_EN so the same bench covers both builds.
module tb_cla_pipe_adder;

`ifdef CLA_PIPE_FLAGS_EN
   localparam logic FL = 1'b1;
`else
   localparam logic FL = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic        op;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] sum;
   logic        cout;
   logic        ovf;
   logic        zero;

   int checks   = 0;
   int failures = 0;
   int tx;
   int rx;

   logic [31:0] sa [6] = '{32'h0000_0010, 32'h0000_0100, 32'h1000_0000,
                           32'h0000_0009, 32'hFFFF_0000, 32'h0000_0000};
   logic [31:0] sb [6] = '{32'h0000_0001, 32'h0000_0002, 32'h1000_0000,
                           32'h0000_0003, 32'h0001_0000, 32'h0000_0001};
   logic        so [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
   logic [31:0] es [6] = '{32'h0000_0011, 32'h0000_0102, 32'h2000_0000,
                           32'h0000_0006, 32'h0000_0000, 32'hFFFF_FFFF};
   logic        ec [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

   cla_pipe_adder #(
      .WIDTH(32),
      .CHUNK(8)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .a        (a),
      .b        (b),
      .op       (op),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .sum      (sum),
      .cout     (cout),
      .ovf      (ovf),
      .zero     (zero)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One isolated operation on an empty pipe with out_ready held high.
   task automatic single(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                         input logic top, input logic [31:0] esum, input logic ecout,
                         input logic eovf, input logic ezero);
      a        = ta;
      b        = tb_v;
      op       = top;
      in_valid = 1'b1;
      #1;
      chk({tag, ".in_ready"}, {31'b0, in_ready}, 32'd1);
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      chk({tag, ".early"}, {31'b0, out_valid}, 32'd0);
      tick();
      chk({tag, ".valid"}, {31'b0, out_valid}, 32'd1);
      chk({tag, ".sum"},   sum, esum);
      chk({tag, ".cout"},  {31'b0, cout}, {31'b0, ecout});
      chk({tag, ".ovf"},   {31'b0, ovf},  {31'b0, eovf});
      chk({tag, ".zero"},  {31'b0, zero}, {31'b0, ezero});
      tick();
      chk({tag, ".drained"}, {31'b0, out_valid}, 32'd0);
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      a         = '0;
      b         = '0;
      op        = 1'b0;
      tick();
      tick();
      chk("reset.out_valid", {31'b0, out_valid}, 32'd0);
      chk("reset.in_ready",  {31'b0, in_ready},  32'd1);
      chk("reset.sum",       sum, 32'd0);
      chk("reset.cout",      {31'b0, cout}, 32'd0);
      chk("reset.ovf",       {31'b0, ovf},  32'd0);
      chk("reset.zero",      {31'b0, zero}, 32'd0);
      rst = 1'b0;
      tick();

      // Empty pipe never back-pressures, even with the consumer stalled.
      out_ready = 1'b0;
      #1;
      chk("empty.in_ready", {31'b0, in_ready}, 32'd1);
      out_ready = 1'b1;
      tick();

      single("add_wrap",  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, FL);
      single("sub_neg",   32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
      single("add_ovf",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, FL,   1'b0);
      single("sub_ovf",   32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, FL,   1'b0);
      single("sub_eq",    32'h1234_5678, 32'h1234_5678, 1'b1, 32'h0000_0000, 1'b1, 1'b0, FL);
      single("add_c1",    32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0);
      single("add_c3",    32'h00FF_FFFF, 32'h0000_0001, 1'b0, 32'h0100_0000, 1'b0, 1'b0, 1'b0);

      // Six back-to-back ops; consumer stalls for cycles 5..7.
      tx = 0;
      rx = 0;
      for (int cyc = 0; cyc < 40 && rx < 6; cyc++) begin
         out_ready = !(cyc >= 5 && cyc <= 7);
         if (tx < 6) begin
            in_valid = 1'b1;
            a        = sa[tx];
            b        = sb[tx];
            op       = so[tx];
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (!out_ready) begin
            chk("stall.in_ready",  {31'b0, in_ready},  32'd0);
            chk("stall.out_valid", {31'b0, out_valid}, 32'd1);
            chk("stall.hold",      sum, es[rx]);
         end
         if (out_valid && out_ready) begin
            chk("stream.sum",  sum, es[rx]);
            chk("stream.cout", {31'b0, cout}, {31'b0, ec[rx]});
            rx++;
         end
         if (in_valid && in_ready) tx++;
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      chk("stream.accepted", tx, 32'd6);
      chk("stream.returned", rx, 32'd6);
      tick();
      chk("stream.empty", {31'b0, out_valid}, 32'd0);

      // Three ops in flight, then a reset cycle discards them.
      in_valid = 1'b1;
      op       = 1'b0;
      b        = 32'h0000_0001;
      a        = 32'h0000_0001;
      tick();
      a        = 32'h0000_0002;
      tick();
      a        = 32'h0000_0003;
      tick();
      in_valid = 1'b0;
      rst      = 1'b1;
      tick();
      chk("rst_mid.out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_mid.in_ready",  {31'b0, in_ready},  32'd1);
      chk("rst_mid.sum",       sum, 32'd0);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("rst_mid.no_stale", {31'b0, out_valid}, 32'd0);
      end
      single("after_rst", 32'h0000_0020, 32'h0000_0022, 1'b0, 32'h0000_0042, 1'b0, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
